// File: rtl/nes_pad_reader.sv
// NES/SNES-style controller reader: latches the pad, clocks out 8 serial bits
// and publishes them active-high on oButtons with a one-cycle oValid strobe.
module nes_pad_reader #(
    parameter int unsigned HALF_CYCLES = 300,
    parameter int unsigned POLL_CYCLES = 833333
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iEnable,
    input  logic       iStart,
    input  logic       iDATA,
    output logic       oLATCH,
    output logic       oPCLK,
    output logic [7:0] oButtons,
    output logic       oValid,
    output logic       oBusy
);

    localparam int unsigned PW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [15:0]   HALF_LAST = 16'(HALF_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [15:0]   presc_q;
    logic [15:0]   presc_d;
    logic [PW-1:0] poll_q;
    logic [PW-1:0] poll_d;
    logic          sync1_q;
    logic          sync2_q;
    logic          lat_half_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          latch_q;
    logic          pclk_q;
    logic          busy_q;
    logic          valid_q;
    logic [7:0]    buttons_q;

    logic tick;
    logic poll_wrap;
    logic start_req;

    assign tick = (presc_q == HALF_LAST) &&
                  ((state_q == S_LATCH) || (state_q == S_BIT_LOW) || (state_q == S_BIT_HIGH));
    assign poll_wrap = iEnable && (poll_q == POLL_LAST);
    assign start_req = iStart || poll_wrap;

    always_comb begin
        presc_d = presc_q + 16'd1;
        if ((state_q == S_IDLE) || (state_q == S_DONE) || tick) begin
            presc_d = '0;
        end
    end

    always_comb begin
        poll_d = poll_q + 1'b1;
        if (!iEnable || poll_wrap) begin
            poll_d = '0;
        end
    end

    // Pad data is asynchronous; only sync2_q is ever sampled.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            poll_q  <= '0;
        end else begin
            sync1_q <= iDATA;
            sync2_q <= sync1_q;
            poll_q  <= poll_d;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            lat_half_q <= 1'b0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            latch_q    <= 1'b0;
            pclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            buttons_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            presc_q <= presc_d;
            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        state_q    <= S_LATCH;
                        latch_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        bit_idx_q  <= '0;
                        lat_half_q <= 1'b0;
                    end
                end
                // Latch spans two prescaler periods.
                S_LATCH: begin
                    if (tick) begin
                        if (lat_half_q) begin
                            state_q <= S_BIT_LOW;
                            latch_q <= 1'b0;
                        end else begin
                            lat_half_q <= 1'b1;
                        end
                    end
                end
                S_BIT_LOW: begin
                    if (tick) begin
                        shift_q[bit_idx_q] <= sync2_q;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_BIT_HIGH;
                            pclk_q  <= 1'b1;
                        end
                    end
                end
                S_BIT_HIGH: begin
                    if (tick) begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                        pclk_q    <= 1'b0;
                        state_q   <= S_BIT_LOW;
                    end
                end
                S_DONE: begin
                    buttons_q <= ~shift_q;
                    valid_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oLATCH   = latch_q;
    assign oPCLK    = pclk_q;
    assign oButtons = buttons_q;
    assign oValid   = valid_q;
    assign oBusy    = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: behavioural pad, scoreboard of expected frames,
// and a negedge monitor tracking latch/clock waveform properties.
module tb_nes_pad_reader;

    localparam int H = 4;
    localparam int P = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       data;
    logic       latch, pclk, valid, busy;
    logic [7:0] buttons;

    nes_pad_reader #(.HALF_CYCLES(H), .POLL_CYCLES(P)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iEnable(en), .iStart(start), .iDATA(data),
        .oLATCH(latch), .oPCLK(pclk), .oButtons(buttons), .oValid(valid), .oBusy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Pad model: latch loads index 0, each PCLK rising edge advances.
    logic [7:0] pad_btn = 8'h00;
    int         hold_mode = 0; // 0 model, 1 hold high, 2 hold low
    logic [3:0] pad_idx = 4'd0;
    logic       pad_pclk_prev = 1'b0;
    always @(posedge clk) begin
        if (latch) pad_idx <= 4'd0;
        else if (pclk && !pad_pclk_prev && pad_idx < 4'd8) pad_idx <= pad_idx + 4'd1;
        pad_pclk_prev <= pclk;
    end
    assign data = (hold_mode == 1) ? 1'b1 :
                  (hold_mode == 2) ? 1'b0 :
                  (pad_idx < 4'd8) ? ~pad_btn[pad_idx[2:0]] : 1'b1;

    // Scoreboard and waveform monitor.
    logic [7:0] exp_q[$];
    int valid_count = 0;
    int last_valid_cyc = 0;
    int latch_run = 0, latch_len = 0;
    int pclk_pulses = 0, high_run = 0, width_bad = 0;
    int rise_cyc[$];
    logic latch_s = 1'b0, pclk_s = 1'b0;

    always @(negedge clk) begin
        if (valid) begin
            valid_count++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
            else check($sformatf("buttons_frame%0d", valid_count), int'(buttons), int'(exp_q.pop_front()));
            $display("frame %0d: oButtons=0x%02h at cycle %0d", valid_count, buttons, cyc);
        end
        if (latch && !latch_s) begin
            rise_cyc.push_back(cyc);
            pclk_pulses = 0;
            width_bad = 0;
            latch_run = 0;
        end
        if (latch) latch_run++;
        if (!latch && latch_s) latch_len = latch_run;
        if (pclk && !pclk_s) begin
            pclk_pulses++;
            high_run = 1;
        end else if (pclk) high_run++;
        if (!pclk && pclk_s && high_run != H) width_bad++;
        latch_s = latch;
        pclk_s = pclk;
    end

    int start_edge = 0;
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int c0 = valid_count;
        bit got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (valid_count != c0) begin got = 1; break; end
        end
        if (!got) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic frame(input logic [7:0] btn, input int mode, input logic [7:0] exp, input string name);
        pad_btn = btn;
        hold_mode = mode;
        exp_q.push_back(exp);
        pulse_start();
        wait_valid(name);
        check({name, "_latency"}, last_valid_cyc - start_edge, 17 * H + 1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int bad = 0;
        int c0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (latch || pclk || valid || busy || buttons != 8'h00) bad++;
        end
        check("idle_after_reset", bad, 0);

        frame(8'h5A, 0, 8'h5A, "pad_5a");
        check("latch_len", latch_len, 2 * H);
        check("pclk_pulses", pclk_pulses, 7);
        check("pclk_width_bad", width_bad, 0);
        frame(8'h00, 1, 8'h00, "data_high");
        frame(8'h00, 2, 8'hFF, "data_low");

        // Second request mid-frame is discarded.
        pad_btn = 8'hC3; hold_mode = 0;
        exp_q.push_back(8'hC3);
        c0 = valid_count;
        pulse_start();
        repeat (19) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_valid("ignore");
        repeat (150) @(negedge clk);
        check("ignore_one_valid", valid_count - c0, 1);

        // Periodic polling: 1000 enabled edges yield 5 frames.
        pad_btn = 8'h3C;
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h3C);
        rise_cyc.delete();
        c0 = valid_count;
        @(negedge clk); en = 1'b1;
        repeat (1000) @(posedge clk);
        @(negedge clk); en = 1'b0;
        repeat (150) @(negedge clk);
        check("poll_frames", valid_count - c0, 5);
        check("poll_latch_rises", rise_cyc.size(), 5);
        bad = 0;
        for (int i = 1; i < rise_cyc.size(); i++)
            if (rise_cyc[i] - rise_cyc[i-1] != P) bad++;
        check("poll_spacing_bad", bad, 0);

        // Asynchronous reset in the middle of BIT_HIGH.
        frame(8'h5A, 0, 8'h5A, "pre_reset");
        c0 = valid_count;
        pad_btn = 8'hFF;
        pulse_start();
        bad = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pclk) begin bad = 0; break; end
        end
        check("reach_bit_high", bad, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pclk", int'(pclk), 0);
        check("rst_latch", int'(latch), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_buttons", int'(buttons), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("no_valid_after_reset", valid_count - c0, 0);
        frame(8'h81, 0, 8'h81, "post_reset");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
